// File: rtl/tue_fifo.sv
// tue_fifo: single-clock synchronous FIFO with first-word fall-through output.
// Status outputs (ready/valid/count/thresholds/overflow) are all registered and
// derived from the next-state occupancy, so none of them depends combinationally
// on an input. Storage is a plain register array that is never reset; the
// pointers and count alone define which entries are live.
//
// Handshake: a push happens on an edge where i_push_valid && o_push_ready, a pop
// on an edge where o_pop_valid && i_pop_ready. Neither side may make its valid
// depend on the other side's ready within the same cycle.
module tue_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = DEPTH - 1,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_push_valid,
  output logic                         o_push_ready,
  input  logic [WIDTH-1:0]             i_push_data,
  output logic                         o_pop_valid,
  input  logic                         i_pop_ready,
  output logic [WIDTH-1:0]             o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic                         o_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY);
  // Threshold flag values that correspond to an empty FIFO.
  localparam logic AF_AT_ZERO = (ALMOST_FULL <= 0);
  localparam logic AE_AT_ZERO = (ALMOST_EMPTY >= 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_push_ready;
  logic             r_pop_valid;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;

  // Next pointers and occupancy; a flush overrides any handshake in the same cycle.
  always_comb begin
    w_push       = i_push_valid && r_push_ready;
    w_pop        = r_pop_valid && i_pop_ready;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (i_clear) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  // Control state: pointers, count and registered status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_push_ready   <= 1'b1;
      r_pop_valid    <= 1'b0;
      r_almost_full  <= AF_AT_ZERO;
      r_almost_empty <= AE_AT_ZERO;
      r_overflow     <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_push_ready   <= (w_count_nxt != FULL_CNT);
      r_pop_valid    <= (w_count_nxt != '0);
      r_almost_full  <= (w_count_nxt >= AF_CNT);
      r_almost_empty <= (w_count_nxt <= AE_CNT);
      if (i_clear) begin
        r_overflow <= 1'b0;
      end else if (i_push_valid && !r_push_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage write; writes are suppressed during reset and flush cycles.
  always_ff @(posedge i_clk) begin
    if (w_push && i_rst_n && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_push_ready   = r_push_ready;
  assign o_pop_valid    = r_pop_valid;
  assign o_pop_data     = r_mem[r_rd_ptr];
  assign o_count        = r_count;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_overflow     = r_overflow;

endmodule
